mem_port_arbiter: RTL and testbench

// Shares one single-port synchronous RAM between instruction fetch (IF) and the
// MEM-stage load/store port of the RV32 pipeline. Issues at most one RAM access
// per cycle, routes read data back to its owner one cycle later, and drives
// per-port stall outputs into the pipeline valid/stall control. Data port has

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_run_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM single-port RAM arbiter.
// Owner encoding is also used by the pipeline debug taps.
`ifndef RV_PIPE_CFG_MAX_D_RUN
`define RV_PIPE_CFG_MAX_D_RUN 4
`endif

package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam int MAX_D_RUN_DEF = `RV_PIPE_CFG_MAX_D_RUN;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  function automatic int run_w(input int max_run);
    return $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_run_counter.sv
// Saturating count of consecutive data grants taken while a fetch waits.
// at_max tells the arbiter to hand the next slot to IF.
module arb_run_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_RUN = MAX_D_RUN_DEF,
  parameter int W       = run_w(MAX_D_RUN_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] run_q,
  output logic         at_max
);

  assign at_max = (run_q == W'(MAX_RUN));

  // count up on inc, hold at MAX_RUN, clear has priority
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      run_q <= '0;
    end else if (inc && !at_max) begin
      run_q <= run_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// One-access-per-cycle arbiter between fetch and load/store for a
// single-port RAM; data wins unless IF has waited MAX_D_RUN grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_D_RUN = MAX_D_RUN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int RW = run_w(MAX_D_RUN);

  owner_e        owner_q;
  owner_e        owner_d;
  logic          grant_d;
  logic          grant_if;
  logic          at_max;
  logic [RW-1:0] run_q;

  // data first; starvation guard yields to a waiting fetch
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (!rst) begin
      grant_d  = d_req && !(at_max && if_req);
      grant_if = if_req && !grant_d;
    end
  end

  arb_run_counter #(
    .MAX_RUN (MAX_D_RUN),
    .W       (RW)
  ) u_run (
    .clk    (clk),
    .rst    (rst),
    .inc    (grant_d && if_req),
    .clr    (grant_if || !if_req),
    .run_q  (run_q),
    .at_max (at_max)
  );

  // issue mux toward the RAM for the granted port
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = if_addr;
    mem_wdata = d_wdata;
    owner_d   = OWN_NONE;
    unique case (1'b1)
      grant_d: begin
        mem_en   = 1'b1;
        mem_addr = d_addr;
        mem_we   = d_we ? d_wstrb : '0;
        owner_d  = OWN_D;
      end
      grant_if: begin
        mem_en  = 1'b1;
        owner_d = OWN_IF;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // remember who owns the access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign if_ack    = !rst && (owner_q == OWN_IF);
  assign d_ack     = !rst && (owner_q == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign stall_if  = if_req && !if_ack;
  assign stall_mem = d_req && !d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random bench for mem_port_arbiter with a RAM model
// and a transaction-level reference of grants, acks and memory.
module tb_mem_port_arbiter;

  localparam int MAXR = 4;

  typedef struct {
    logic        we;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dop_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_RUN(MAXR)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  function automatic logic [31:0] pat(input int k);
    logic [31:0] v;
    v = 32'(k);
    return 32'h5A5A_0000 ^ (v * 32'h9E37_79B1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
      input logic [31:0] nw, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // RAM environment: one-cycle read latency, byte writes
  logic [31:0] ram [int];
  logic [31:0] ram_rd = '0;
  assign mem_rdata = ram_rd;
  always @(posedge clk) begin : ram_p
    int k;
    logic [31:0] w;
    if (mem_en) begin
      k = int'(mem_addr[11:2]);
      w = ram.exists(k) ? ram[k] : pat(k);
      ram_rd <= w;
      ram[k] = merge(w, mem_wdata, mem_we);
    end
  end

  // reference state
  logic [31:0] sh [int];
  int          own_m = 0;
  int          run_m = 0;
  logic [31:0] exp_rd_m = '0;
  logic        st_m = 1'b0;
  int          cyc = 0;
  bit          rnd = 1'b0;
  logic [31:0] if_q [$];
  dop_t        d_q [$];
  int          ack_tags [$];
  int          if_ack_cyc [$];
  int          c4_hits = 0;
  logic [31:0] last_d_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
      input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sh_rd(input logic [31:0] a);
    int k;
    k = int'(a[11:2]);
    return sh.exists(k) ? sh[k] : pat(k);
  endfunction

  // requesters: hold until the expected ack, then move on
  task automatic drive();
    bit ai, ad, hi, hd;
    ai = (own_m == 1) && !rst;
    ad = (own_m == 2) && !rst;
    if (ai && if_q.size() > 0) void'(if_q.pop_front());
    if (ad && d_q.size() > 0) void'(d_q.pop_front());
    hi = if_req && !ai;
    hd = d_req && !ad;
    if_req = if_q.size() > 0 &&
             (hi || !rnd || ($urandom_range(2) != 0));
    d_req  = d_q.size() > 0 &&
             (hd || !rnd || ($urandom_range(2) != 0));
    if (if_q.size() > 0) if_addr = if_q[0];
    if (d_q.size() > 0) begin
      d_we    = d_q[0].we;
      d_wstrb = d_q[0].strb;
      d_addr  = d_q[0].addr;
      d_wdata = d_q[0].wdata;
    end
  endtask

  task automatic check();
    bit ei, ed;
    int g;
    logic [3:0] we_x;
    ei = (own_m == 1) && !rst;
    ed = (own_m == 2) && !rst;
    chk("if_ack", 32'(if_ack), 32'(ei));
    chk("d_ack", 32'(d_ack), 32'(ed));
    if (ei) chk("if_rdata", if_rdata, exp_rd_m);
    if (ed && !st_m) begin
      chk("d_rdata", d_rdata, exp_rd_m);
      last_d_rd = d_rdata;
    end
    chk("stall_if", 32'(stall_if), 32'(if_req && !ei));
    chk("stall_mem", 32'(stall_mem), 32'(d_req && !ed));
    if (if_ack) begin
      ack_tags.push_back(1);
      if_ack_cyc.push_back(cyc);
    end
    if (d_ack) ack_tags.push_back(2);
    if (mem_en && mem_addr == 32'hC4) c4_hits++;
    g = 0;
    if (!rst) begin
      if (d_req && !(run_m == MAXR && if_req)) g = 2;
      else if (if_req) g = 1;
    end
    we_x = (g == 2 && d_we) ? d_wstrb : 4'h0;
    chk("mem_en", 32'(mem_en), 32'(g != 0));
    chk("mem_we", 32'(mem_we), 32'(we_x));
    if (g == 1) begin
      chk("mem_addr_if", mem_addr, if_addr);
      exp_rd_m = sh_rd(if_addr);
      st_m = 1'b0;
    end
    if (g == 2) begin
      chk("mem_addr_d", mem_addr, d_addr);
      exp_rd_m = sh_rd(d_addr);
      st_m = d_we;
      if (d_we) begin
        chk("mem_wdata", mem_wdata, d_wdata);
        sh[int'(d_addr[11:2])] = merge(exp_rd_m, d_wdata, d_wstrb);
      end
    end
    if (rst) run_m = 0;
    else if (g == 2 && if_req) run_m = (run_m < MAXR) ? run_m + 1 : run_m;
    else if (g == 1 || !if_req) run_m = 0;
    own_m = g;
  endtask

  task automatic step();
    drive();
    #4;
    check();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int c0;
    dop_t op;
    @(posedge clk);
    #1;
    // reset state
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // back-to-back fetches
    if_ack_cyc.delete();
    if_q.push_back(32'h0);
    if_q.push_back(32'h4);
    if_q.push_back(32'h8);
    c0 = cyc;
    idle(5);
    chk("fetch_acks", 32'(if_ack_cyc.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk("fetch_ack_cyc", 32'(if_ack_cyc[k]), 32'(c0 + 1 + k));

    // partial store then load
    op.we = 1'b1; op.strb = 4'b0011;
    op.addr = 32'h100; op.wdata = 32'hDEAD_BEEF;
    d_q.push_back(op);
    op.we = 1'b0; op.strb = 4'b0000; op.wdata = '0;
    d_q.push_back(op);
    idle(4);
    chk("partial_load", last_d_rd,
        {pat(32'h100 >> 2) & 32'hFFFF_0000} | 32'h0000_BEEF);

    // starvation guard
    ack_tags.delete();
    if_q.push_back(32'h40);
    for (int k = 0; k < 6; k++) begin
      op.we = 1'b0; op.strb = '0;
      op.addr = 32'h200 + 32'(4 * k); op.wdata = '0;
      d_q.push_back(op);
    end
    idle(9);
    chk("guard_n", 32'(ack_tags.size()), 32'd7);
    for (int k = 0; k < 6; k++)
      chk("guard_seq", 32'(ack_tags[k]), (k == 4) ? 32'd1 : 32'd2);

    // reset right after an IF grant
    if_ack_cyc.delete();
    if_q.push_back(32'h80);
    c0 = cyc;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(4);
    chk("rst_acks", 32'(if_ack_cyc.size()), 32'd1);
    chk("rst_ack_cyc", 32'(if_ack_cyc[0]), 32'(c0 + 3));

    // fetch dropped after grant still acks once
    if_ack_cyc.delete();
    if_q.push_back(32'hC0);
    step();
    if_q.delete();
    idle(4);
    chk("flush_acks", 32'(if_ack_cyc.size()), 32'd1);

    // fetch flushed while waiting is never issued
    if_ack_cyc.delete();
    c4_hits = 0;
    for (int k = 0; k < 3; k++) begin
      op.we = 1'b0; op.strb = '0;
      op.addr = 32'h300 + 32'(4 * k); op.wdata = '0;
      d_q.push_back(op);
    end
    if_q.push_back(32'hC4);
    idle(2);
    if_q.delete();
    idle(4);
    chk("flush_wait_acks", 32'(if_ack_cyc.size()), 32'd0);
    chk("flush_wait_issue", 32'(c4_hits), 32'd0);

    // random traffic
    rnd = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (if_q.size() < 3 && $urandom_range(3) == 0)
        if_q.push_back({20'h0, 10'($urandom), 2'b00});
      if (d_q.size() < 3 && $urandom_range(2) == 0) begin
        op.we    = 1'($urandom);
        op.strb  = op.we ? 4'($urandom_range(15, 1)) : 4'h0;
        op.addr  = {20'h0, 4'($urandom), 6'($urandom), 2'b00};
        op.wdata = $urandom;
        d_q.push_back(op);
      end
      rst = ($urandom_range(63) == 0);
      step();
    end
    rst = 1'b0;
    rnd = 1'b0;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
